// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner family.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } scan_state_t;

   localparam int DEF_ROWS            = 4;
   localparam int DEF_COLS            = 4;
   localparam int DEF_SCAN_DIV        = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 8;
   localparam int DEF_SYNC_STAGES     = 2;

   // Width of an encoded key index row*cols+col; never narrower than one bit.
   function automatic int code_width(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_bus.sv
// N-bit multi-flop synchroniser for asynchronous level inputs; idles at all-ones.
module sync_bus
   import keypad_pkg::*;
#(
   parameter int WIDTH  = DEF_COLS,
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] pipe;

   // NOTE: reset is sampled on the clock edge only, so it sits inside the
   // edge-triggered block rather than in the sensitivity list.
   always_ff @(posedge clk) begin
      if (reset) pipe <= '1;
      else       pipe <= {pipe[STAGES-2:0], d};
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/keypad_scan_debounce.sv
// Row/column keypad scanner with dwell, press/release debounce, row hold,
// single key-event pulse and multi-key detection.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter int ROWS            = DEF_ROWS,
   parameter int COLS            = DEF_COLS,
   parameter int SCAN_DIV        = DEF_SCAN_DIV,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [COLS-1:0]                    cols_n,
   output logic [ROWS-1:0]                    rows_n,
   output logic                               key_valid,
   output logic [code_width(ROWS, COLS)-1:0]  key_code,
   output logic                               key_held,
   output logic                               multi_err
);

   localparam int CW    = code_width(ROWS, COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int CLW   = $clog2(COLS);
   localparam int CNT_W = $clog2(max2(SCAN_DIV, DEBOUNCE_CYCLES) + 1);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0]    ROW_LAST   = RW'(ROWS - 1);

   if (ROWS < 2) begin : g_bad_rows
      $error("keypad_scan_debounce: ROWS must be >= 2");
   end
   if (COLS < 2) begin : g_bad_cols
      $error("keypad_scan_debounce: COLS must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("keypad_scan_debounce: SYNC_STAGES must be >= 2");
   end
   if (SCAN_DIV < SYNC_STAGES + 2) begin : g_bad_div
      $error("keypad_scan_debounce: SCAN_DIV must be >= SYNC_STAGES+2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $error("keypad_scan_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [COLS-1:0]  cs;
   scan_state_t      state;
   logic [RW-1:0]    row;
   logic [RW-1:0]    next_row;
   logic [CNT_W-1:0] dwell;
   logic [CNT_W-1:0] cnt;
   logic [RW-1:0]    cand_row;
   logic [CLW-1:0]   cand_col;
   logic [CLW-1:0]   first_low;
   logic [COLS-1:0]  low_bits;
   logic             low_any;
   logic             low_multi;
   logic             cand_open;

   sync_bus #(
      .WIDTH  (COLS),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (cols_n),
      .q     (cs)
   );

   function automatic logic [ROWS-1:0] one_cold(input logic [RW-1:0] idx);
      return ~(ROWS'(1) << idx);
   endfunction

   assign low_bits  = ~cs;
   assign low_any   = |low_bits;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign low_multi = |(low_bits & (low_bits - 1'b1));
   assign cand_open = cs[cand_col];
   assign next_row  = (row == ROW_LAST) ? '0 : row + 1'b1;

   // NOTE: the default assignment before the loop keeps this purely
   // combinational; without it an all-high cs would infer a latch.
   always_comb begin
      first_low = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (!cs[c]) first_low = CLW'(c);
      end
   end

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the pre-edge values and the block order does not matter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         row       <= '0;
         rows_n    <= one_cold('0);
         dwell     <= '0;
         cnt       <= '0;
         cand_row  <= '0;
         cand_col  <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_held  <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         multi_err <= 1'b0;
         unique case (state)
            SCAN: begin
               if (dwell == DWELL_LAST) begin
                  if (!low_any) begin
                     row    <= next_row;
                     rows_n <= one_cold(next_row);
                     dwell  <= '0;
                  end else begin
                     cand_row  <= row;
                     cand_col  <= first_low;
                     multi_err <= low_multi;
                     cnt       <= '0;
                     state     <= DEBOUNCE;
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            DEBOUNCE: begin
               // A high sample always wins, even on the completing cycle.
               if (cand_open) begin
                  state  <= SCAN;
                  row    <= next_row;
                  rows_n <= one_cold(next_row);
                  dwell  <= '0;
               end else if (cnt == DB_LAST) begin
                  state     <= HELD;
                  cnt       <= '0;
                  key_valid <= 1'b1;
                  key_code  <= CW'(cand_row) * CW'(COLS) + CW'(cand_col);
                  key_held  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (!cand_open) begin
                  cnt <= '0;
               end else if (cnt == DB_LAST) begin
                  key_held <= 1'b0;
                  cnt      <= '0;
                  state    <= SCAN;
                  row      <= next_row;
                  rows_n   <= one_cold(next_row);
                  dwell    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench: keypad matrix model, behavioural reference, per-cycle compare.
module tb_keypad_scan_debounce;

   logic clk;
   logic reset;

   // Default instance 4x4, debounce 8
   logic [3:0] cols0, rows0;
   logic       kv0, kh0, me0;
   logic [3:0] kc0;
   // Small instance 2x3, debounce 1
   logic [2:0] cols1;
   logic [1:0] rows1;
   logic       kv1, kh1, me1;
   logic [2:0] kc1;

   logic [3:0] press0 [4];
   logic [3:0] bounce0;
   logic [2:0] press1 [2];
   logic [2:0] bounce1;

   int passed = 0;
   int total  = 0;
   bit cmp_en = 0;

   keypad_scan_debounce dut0 (
      .clk(clk), .reset(reset), .cols_n(cols0), .rows_n(rows0),
      .key_valid(kv0), .key_code(kc0), .key_held(kh0), .multi_err(me0)
   );

   keypad_scan_debounce #(
      .ROWS(2), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)
   ) dut1 (
      .clk(clk), .reset(reset), .cols_n(cols1), .rows_n(rows1),
      .key_valid(kv1), .key_code(kc1), .key_held(kh1), .multi_err(me1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its column to the row being driven low.
   always_comb begin
      cols0 = '1;
      for (int r = 0; r < 4; r++)
         if (rows0[r] == 1'b0) cols0 = cols0 & ~(press0[r] & ~bounce0);
   end
   always_comb begin
      cols1 = '1;
      for (int r = 0; r < 2; r++)
         if (rows1[r] == 1'b0) cols1 = cols1 & ~(press1[r] & ~bounce1);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural reference ----------------
   localparam int PH_SCAN = 0, PH_CONFIRM = 1, PH_HOLD = 2;
   int m_phase[2], m_row[2], m_elapsed[2], m_run[2];
   int m_cr[2], m_cc[2], m_sync_a[2], m_sync_b[2];
   int m_rows_n[2], m_kc[2];
   bit m_kv[2], m_kh[2], m_me[2];

   task automatic model_step(input int id, input int nr, input int nc, input int sd,
                             input int db, input int cin, input bit rst);
      int cs, lows, first, all1;
      all1 = (1 << nc) - 1;
      cs   = m_sync_b[id];
      if (rst) begin
         m_phase[id] = PH_SCAN; m_row[id] = 0; m_elapsed[id] = 0; m_run[id] = 0;
         m_cr[id] = 0; m_cc[id] = 0; m_kv[id] = 0; m_kc[id] = 0; m_kh[id] = 0;
         m_me[id] = 0; m_sync_a[id] = all1; m_sync_b[id] = all1;
      end else begin
         m_kv[id] = 0;
         m_me[id] = 0;
         if (m_phase[id] == PH_SCAN) begin
            if (m_elapsed[id] == sd - 1) begin
               lows = 0; first = -1;
               for (int c = 0; c < nc; c++)
                  if (((cs >> c) & 1) == 0) begin
                     lows++;
                     if (first < 0) first = c;
                  end
               if (lows == 0) begin
                  m_row[id] = (m_row[id] + 1) % nr; m_elapsed[id] = 0;
               end else begin
                  m_cr[id] = m_row[id]; m_cc[id] = first; m_me[id] = (lows > 1);
                  m_phase[id] = PH_CONFIRM; m_run[id] = 0;
               end
            end else m_elapsed[id]++;
         end else if (m_phase[id] == PH_CONFIRM) begin
            if (((cs >> m_cc[id]) & 1) == 0) begin
               m_run[id]++;
               if (m_run[id] == db) begin
                  m_phase[id] = PH_HOLD; m_run[id] = 0; m_kv[id] = 1; m_kh[id] = 1;
                  m_kc[id] = m_cr[id] * nc + m_cc[id];
               end
            end else begin
               m_phase[id] = PH_SCAN; m_row[id] = (m_row[id] + 1) % nr; m_elapsed[id] = 0;
            end
         end else begin
            if (((cs >> m_cc[id]) & 1) == 1) begin
               m_run[id]++;
               if (m_run[id] == db) begin
                  m_kh[id] = 0; m_run[id] = 0; m_phase[id] = PH_SCAN;
                  m_row[id] = (m_row[id] + 1) % nr; m_elapsed[id] = 0;
               end
            end else m_run[id] = 0;
         end
         m_sync_b[id] = m_sync_a[id];
         m_sync_a[id] = cin;
      end
      m_rows_n[id] = ((1 << nr) - 1) & ~(1 << m_row[id]);
   endtask

   always @(posedge clk) begin
      model_step(0, 4, 4, 4, 8, int'(cols0), reset);
      model_step(1, 2, 3, 4, 1, int'(cols1), reset);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("rows_n0",    int'(rows0), m_rows_n[0]);
         check("key_valid0", int'(kv0),   int'(m_kv[0]));
         check("key_code0",  int'(kc0),   m_kc[0]);
         check("key_held0",  int'(kh0),   int'(m_kh[0]));
         check("multi_err0", int'(me0),   int'(m_me[0]));
         check("rows_n1",    int'(rows1), m_rows_n[1]);
         check("key_valid1", int'(kv1),   int'(m_kv[1]));
         check("key_code1",  int'(kc1),   m_kc[1]);
         check("key_held1",  int'(kh1),   int'(m_kh[1]));
         check("multi_err1", int'(me1),   int'(m_me[1]));
      end
   end

   // Event counters sampled on posedge so they are stable at every negedge.
   int kv_cnt0 = 0, me_cnt0 = 0, kv_cnt1 = 0, last_code0 = -1, last_code1 = -1;
   always @(posedge clk) begin
      if (kv0 === 1'b1) begin kv_cnt0 <= kv_cnt0 + 1; last_code0 <= int'(kc0); end
      if (me0 === 1'b1) me_cnt0 <= me_cnt0 + 1;
      if (kv1 === 1'b1) begin kv_cnt1 <= kv_cnt1 + 1; last_code1 <= int'(kc1); end
   end

   function automatic bit get_kh(input int id);
      return (id == 0) ? kh0 : kh1;
   endfunction

   task automatic wait_held(input int id, input bit val, input int max_cyc,
                            input string name, output int n);
      n = 0;
      while (get_kh(id) !== val && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(get_kh(id)), int'(val));
   endtask

   task automatic clear_keys();
      press0  = '{default: '0};
      press1  = '{default: '0};
      bounce0 = '0;
      bounce1 = '0;
   endtask

   logic [3:0] t1_exp0 [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
   logic [1:0] t1_exp1 [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      int n, snap, snap_me, r, c, dur;
      reset = 1'b1;
      clear_keys();
      @(negedge clk);
      cmp_en = 1;
      reset  = 1'b0;

      // 1: idle scan pattern, 4 cycles per row, wrap on both instances
      snap = kv_cnt0;
      for (int k = 0; k < 20; k++) begin
         check("idle_rows0", int'(rows0), int'(t1_exp0[k / 4]));
         check("idle_rows1", int'(rows1), int'(t1_exp1[k / 4]));
         @(negedge clk);
      end
      check("idle_no_pulse", kv_cnt0 - snap, 0);

      // 2: row 1 / col 2 solid, a short release bounce, then real release
      snap = kv_cnt0;
      press0[1] = 4'b0100;
      wait_held(0, 1'b1, 100, "t2_held", n);
      repeat (50) @(negedge clk);
      check("t2_pulses", kv_cnt0 - snap, 1);
      check("t2_code", last_code0, 6);
      press0[1] = 4'b0000;
      repeat (3) @(negedge clk);
      press0[1] = 4'b0100;
      repeat (20) @(negedge clk);
      check("t2_bounce_held", int'(kh0), 1);
      check("t2_no_repeat", kv_cnt0 - snap, 1);
      press0[1] = 4'b0000;
      wait_held(0, 1'b0, 40, "t2_release", n);
      check("t2_release_latency", n, 10);
      check("t2_next_row", int'(rows0), int'(4'b1011));

      // 3: row 3 / col 0 bouncing on the first visit, then solid
      n = 0;
      while (rows0 == 4'b0111 && n < 40) begin @(negedge clk); n++; end
      n = 0;
      while (rows0 != 4'b0111 && n < 40) begin @(negedge clk); n++; end
      check("t3_row3_seen", int'(rows0), int'(4'b0111));
      snap = kv_cnt0;
      press0[3] = 4'b0001;
      repeat (3) @(negedge clk);
      bounce0 = 4'b0001;
      @(negedge clk);
      bounce0 = 4'b0000;
      repeat (16) @(negedge clk);
      check("t3_abandoned", kv_cnt0 - snap, 0);
      repeat (40) @(negedge clk);
      check("t3_pulses", kv_cnt0 - snap, 1);
      check("t3_code", last_code0, 12);
      press0[3] = 4'b0000;
      wait_held(0, 1'b0, 40, "t3_release", n);

      // 4: row 0 with cols 1 and 3 low
      snap = kv_cnt0; snap_me = me_cnt0;
      press0[0] = 4'b1010;
      wait_held(0, 1'b1, 100, "t4_held", n);
      repeat (30) @(negedge clk);
      check("t4_multi", me_cnt0 - snap_me, 1);
      check("t4_pulses", kv_cnt0 - snap, 1);
      check("t4_code", last_code0, 1);
      press0[0] = 4'b0000;
      wait_held(0, 1'b0, 40, "t4_release", n);

      // 5: reset while a key is held, then re-detection
      press0[2] = 4'b0010;
      wait_held(0, 1'b1, 100, "t5_held", n);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_rst_held", int'(kh0), 0);
      check("t5_rst_rows", int'(rows0), int'(4'b1110));
      check("t5_rst_valid", int'(kv0), 0);
      snap = kv_cnt0;
      wait_held(0, 1'b1, 100, "t5_redetect", n);
      repeat (2) @(negedge clk);
      check("t5_pulses", kv_cnt0 - snap, 1);
      check("t5_code", last_code0, 9);
      press0[2] = 4'b0000;
      wait_held(0, 1'b0, 40, "t5_release", n);

      // 6: small instance, row 1 / col 2
      snap = kv_cnt1;
      press1[1] = 3'b100;
      wait_held(1, 1'b1, 60, "t6_held", n);
      repeat (10) @(negedge clk);
      check("t6_pulses", kv_cnt1 - snap, 1);
      check("t6_code", last_code1, 5);
      press1[1] = 3'b000;
      wait_held(1, 1'b0, 20, "t6_release", n);

      // Random presses with contact chatter, occasional reset
      for (int it = 0; it < 30; it++) begin
         clear_keys();
         r = $urandom_range(0, 3); c = $urandom_range(0, 3);
         press0[r][c] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 3); c = $urandom_range(0, 3);
            press0[r][c] = 1'b1;
         end
         r = $urandom_range(0, 1); c = $urandom_range(0, 2);
         press1[r][c] = 1'b1;
         dur = $urandom_range(20, 120);
         for (int t = 0; t < dur; t++) begin
            bounce0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            bounce1 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            reset   = (t == dur / 2) && ($urandom_range(0, 9) == 0);
            @(negedge clk);
         end
         reset = 1'b0;
         dur = $urandom_range(5, 80);
         for (int t = 0; t < dur; t++) begin
            bounce0 = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'b1111;
            bounce1 = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'b111;
            @(negedge clk);
         end
      end
      clear_keys();
      repeat (50) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
